// File: rtl/vedic_mul_pipe.sv
// Four-stage pipelined WIDTH x WIDTH Urdhva (quadrant) multiplier with valid/ready, signed mode and tag.
// Optional completed-operation counter on op_count is built when VEDIC_MUL_CNT_EN is defined.
module vedic_mul_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [TAG_W-1:0]   out_tag
`ifdef VEDIC_MUL_CNT_EN
  ,
  output logic [31:0]        op_count
`endif
);

  localparam int W = WIDTH;
  localparam int H = WIDTH / 2;

  // Two's-complement fix-up of the unsigned high half, taken mod 2^W.
  function automatic logic [W-1:0] sign_corr(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    logic [W-1:0] cx;
    logic [W-1:0] cy;
    cx = (s & x[W-1]) ? y : '0;
    cy = (s & y[W-1]) ? x : '0;
    return cx + cy;
  endfunction

  logic stall;
  logic vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;

  logic [W-1:0]     ll_p1_q, lh_p1_q, hl_p1_q, hh_p1_q;
  logic [W-1:0]     a_p1_q, b_p1_q;
  logic             sgn_p1_q;
  logic [TAG_W-1:0] tag_p1_q;

  logic [W:0]       mid_p2_q;
  logic [W-1:0]     ll_p2_q, hh_p2_q, a_p2_q, b_p2_q;
  logic             sgn_p2_q;
  logic [TAG_W-1:0] tag_p2_q;

  logic [W+1:0]     mid2_p3_q;
  logic [H-1:0]     lll_p3_q;
  logic [W-1:0]     hh_p3_q, a_p3_q, b_p3_q;
  logic             sgn_p3_q;
  logic [TAG_W-1:0] tag_p3_q;

  logic [W-1:0]     ll_p1_d, lh_p1_d, hl_p1_d, hh_p1_d;
  logic [W:0]       mid_p2_d;
  logic [W+1:0]     mid2_p3_d;
  logic [W-1:0]     hi_p4_d;
  logic [2*W-1:0]   result_p4_d;
  logic [2*W-1:0]   result_q;
  logic [TAG_W-1:0] tag_p4_q;

  assign stall     = vld_p4_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_p4_q;
  assign result    = result_q;
  assign out_tag   = tag_p4_q;

  // Stage 1: four HxH partial products
  assign ll_p1_d = W'(a[H-1:0]) * W'(b[H-1:0]);
  assign lh_p1_d = W'(a[H-1:0]) * W'(b[W-1:H]);
  assign hl_p1_d = W'(a[W-1:H]) * W'(b[H-1:0]);
  assign hh_p1_d = W'(a[W-1:H]) * W'(b[W-1:H]);

  // Stage 2: cross-term sum
  assign mid_p2_d = {1'b0, lh_p1_q} + {1'b0, hl_p1_q};

  // Stage 3: fold the carry half of ll into the middle sum
  assign mid2_p3_d = {1'b0, mid_p2_q} + (W+2)'(ll_p2_q[W-1:H]);

  // Stage 4: high word with signed correction, output assembly
  assign hi_p4_d     = hh_p3_q + W'(mid2_p3_q[W+1:H]) - sign_corr(a_p3_q, b_p3_q, sgn_p3_q);
  assign result_p4_d = {hi_p4_d, mid2_p3_q[H-1:0], lll_p3_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
      result_q <= '0;
      tag_p4_q <= '0;
    end else if (!stall) begin
      vld_p1_q <= in_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      vld_p4_q <= vld_p3_q;
      result_q <= result_p4_d;
      tag_p4_q <= tag_p3_q;
    end
  end

  // Intermediate datapath carries no reset; validity is tracked by vld_pN alone.
  always_ff @(posedge clk) begin
    if (!stall) begin
      ll_p1_q   <= ll_p1_d;
      lh_p1_q   <= lh_p1_d;
      hl_p1_q   <= hl_p1_d;
      hh_p1_q   <= hh_p1_d;
      a_p1_q    <= a;
      b_p1_q    <= b;
      sgn_p1_q  <= is_signed;
      tag_p1_q  <= in_tag;

      mid_p2_q  <= mid_p2_d;
      ll_p2_q   <= ll_p1_q;
      hh_p2_q   <= hh_p1_q;
      a_p2_q    <= a_p1_q;
      b_p2_q    <= b_p1_q;
      sgn_p2_q  <= sgn_p1_q;
      tag_p2_q  <= tag_p1_q;

      mid2_p3_q <= mid2_p3_d;
      lll_p3_q  <= ll_p2_q[H-1:0];
      hh_p3_q   <= hh_p2_q;
      a_p3_q    <= a_p2_q;
      b_p3_q    <= b_p2_q;
      sgn_p3_q  <= sgn_p2_q;
      tag_p3_q  <= tag_p2_q;
    end
  end

`ifdef VEDIC_MUL_CNT_EN
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign cnt_d    = cnt_q + 32'd1;
  assign op_count = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (vld_p4_q && out_ready) begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Self-checking bench for vedic_mul_pipe (WIDTH=32, TAG_W=4): vector table, scoreboard, stall/reset cases.
module tb_vedic_mul_pipe;

  typedef logic [67:0] ent_t;  // {tag, result}

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [3:0]  tag;
    logic [63:0] exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [3:0]  out_tag;
`ifdef VEDIC_MUL_CNT_EN
  logic [31:0] op_count;
`endif

  int compared;
  int mismatched;
  ent_t exp_q[$];
  ent_t obs[$];
  vec_t vt[10];

  vedic_mul_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .is_signed(is_signed),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .out_tag(out_tag)
`ifdef VEDIC_MUL_CNT_EN
    ,
    .op_count(op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every delivery; handshake completes at the following rising edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) obs.push_back({out_tag, result});
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] sp;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      sp = sx * sy;
      return sp;
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s,
                      input logic [3:0] t, input logic [63:0] e);
    int g;
    a = x; b = y; is_signed = s; in_tag = t; in_valid = 1'b1;
    #1;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #2;
      g++;
    end
    if (g >= 100) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    exp_q.push_back({t, e});
    #1;
  endtask

  task automatic measure_latency(input string name);
    int lat;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check(name, 64'(lat), 64'd4);
  endtask

  task automatic drain();
    int g;
    ent_t e;
    ent_t o;
    g = 0;
    out_ready = 1'b1;
    while (obs.size() < exp_q.size() && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (6) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL missing_result: got none, expected tag %0d result 0x%h", e[67:64], e[63:0]);
      end else begin
        o = obs.pop_front();
        check("result", o[63:0], e[63:0]);
        check("tag", 64'(o[67:64]), 64'(e[67:64]));
      end
    end
    compared++;
    if (obs.size() != 0) begin
      mismatched++;
      $display("FAIL extra_result: got %0d extra deliveries, expected 0", obs.size());
      obs.delete();
    end
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic        iv;
    logic        acc;
    int          sent;
    int          n;
    int          first;
    int          last;

    compared = 0;
    mismatched = 0;

    vt[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd3, 64'hFFFFFFFE00000001};
    vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'd1, 64'h0000000000000001};
    vt[2] = '{32'h80000000, 32'h80000000, 1'b1, 4'd2, 64'h4000000000000000};
    vt[3] = '{32'h80000000, 32'h00000001, 1'b1, 4'd4, 64'hFFFFFFFF80000000};
    vt[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 4'd5, 64'h3FFFFFFF00000001};
    vt[5] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 4'd6, 64'hC000000080000000};
    vt[6] = '{32'hFFFFFFFF, 32'h00000005, 1'b1, 4'd7, 64'hFFFFFFFFFFFFFFFB};
    vt[7] = '{32'hFFFFFFFF, 32'h00000005, 1'b0, 4'd8, 64'h00000004FFFFFFFB};
    vt[8] = '{32'h80000000, 32'h80000000, 1'b0, 4'd9, 64'h4000000000000000};
    vt[9] = '{32'h00000000, 32'hDEADBEEF, 1'b1, 4'd10, 64'h0000000000000000};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; is_signed = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    reset = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Single op: latency, then the rest of the table back to back.
    send(vt[0].a, vt[0].b, vt[0].s, vt[0].tag, vt[0].exp);
    measure_latency("latency_first");
    drain();
    for (int i = 1; i < 10; i++) send(vt[i].a, vt[i].b, vt[i].s, vt[i].tag, vt[i].exp);
    in_valid = 1'b0;
    drain();

    // Eight back-to-back mixed-mode ops must emerge as eight contiguous valid cycles.
    n = 0; first = -1; last = -1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          x = $urandom; y = $urandom;
          s = i[0];
          send(x, y, s, i[3:0], ref_mul(x, y, s));
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 24; i++) begin
          @(posedge clk); #2;
          if (out_valid) begin
            if (first < 0) first = i;
            last = i;
            n++;
          end
        end
      end
    join
    check("burst_count", 64'(n), 64'd8);
    check("burst_contiguous", 64'(last - first), 64'd7);
    drain();

    // Backpressure with a full pipe: outputs hold and input is refused.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom;
      s = ~i[0];
      send(x, y, s, 4'(i + 11), ref_mul(x, y, s));
    end
    a = 32'h12345678; b = 32'h9ABCDEF0; is_signed = 1'b1; in_tag = 4'hF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_result", result, exp_q[0][63:0]);
      check("stall_tag", 64'(out_tag), 64'(exp_q[0][67:64]));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_no_delivery", 64'(obs.size()), 64'd0);
    drain();

    // Random traffic with random bubbles and backpressure.
    sent = 0;
    for (int cyc = 0; cyc < 400 && sent < 16; cyc++) begin
      x = $urandom; y = $urandom;
      s = 1'($urandom_range(0, 1));
      iv = ($urandom_range(0, 3) != 0);
      a = x; b = y; is_signed = s; in_tag = sent[3:0]; in_valid = iv;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = iv && in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back({sent[3:0], ref_mul(x, y, s)});
        sent++;
      end
      #1;
    end
    in_valid = 1'b0;
    check("random_sent", 64'(sent), 64'd16);
    drain();

    // Reset while results are in flight discards them all.
    for (int i = 0; i < 3; i++) send(32'h00010000 + i, 32'h00010000, 1'b0, 4'(i), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("preflush_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_result", result, 64'd0);
    exp_q.delete();
    obs.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("flush_no_stale", 64'(n), 64'd0);
    send(32'hFFFFFFFF, 32'h00000002, 1'b1, 4'd9, 64'hFFFFFFFFFFFFFFFE);
    measure_latency("latency_after_reset");
    drain();

`ifdef VEDIC_MUL_CNT_EN
    reset = 1'b0;
    #1;
    check("count_reset", 64'(op_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          x = $urandom; y = $urandom;
          send(x, y, 1'b0, i[3:0], ref_mul(x, y, 1'b0));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("count_value", 64'(op_count), 64'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
